// File: rtl/bus_memory_if.sv
// Processor request bus plus program-loader byte stream for bus_memory.
// The slave modport is the memory side; the master modport drives requests and load bytes.
interface bus_memory_if #(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned DATA_W = 16
);
   logic              m_en;
   logic              m_rw;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_data;
   logic [DATA_W-1:0] m_q;
   logic              m_ready;
   logic              ld_valid;
   logic [7:0]        ld_byte;
   logic              ld_last;
   logic              ld_ready;
   logic              run;
   logic [DATA_W-1:0] io_out;

   modport slave (
      input  m_en, m_rw, m_addr, m_data, ld_valid, ld_byte, ld_last,
      output m_q, m_ready, ld_ready, run, io_out
   );

   modport master (
      output m_en, m_rw, m_addr, m_data, ld_valid, ld_byte, ld_last,
      input  m_q, m_ready, ld_ready, run, io_out
   );
endinterface

// File: rtl/bus_memory.sv
// Word memory filled from a big-endian byte stream, then served to a processor bus
// with one-cycle read latency and a memory-mapped output register at IO_ADDR.
module bus_memory #(
   parameter int unsigned      ADDR_W  = 12,
   parameter int unsigned      DATA_W  = 16,
   parameter logic [ADDR_W-1:0] IO_ADDR = 12'hFFF
) (
   input logic          clock,
   input logic          reset,
   bus_memory_if.slave  bus
);

   typedef enum logic [1:0] {
      StLoadHi,
      StLoadLo,
      StRun
   } state_e;

   state_e            state_q, state_d;
   logic [7:0]        hi_q, hi_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0] m_q_q, m_q_d;
   logic              m_ready_q, m_ready_d;
   logic [DATA_W-1:0] io_q, io_d;

   logic              ld_we;
   logic              rd_req;
   logic              wr_req;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      cnt_d   = cnt_q;
      ld_we   = 1'b0;
      unique case (state_q)
         StLoadHi: begin
            // ld_last on a high byte is ignored; the word always completes first
            if (bus.ld_valid) begin
               hi_d    = bus.ld_byte;
               state_d = StLoadLo;
            end
         end
         StLoadLo: begin
            if (bus.ld_valid) begin
               ld_we   = 1'b1;
               cnt_d   = cnt_q + ADDR_W'(1);
               state_d = bus.ld_last ? StRun : StLoadHi;
            end
         end
         StRun: begin
         end
         default: state_d = StLoadHi;
      endcase
   end

   always_comb begin
      rd_req    = (state_q == StRun) && bus.m_en && !bus.m_rw;
      wr_req    = (state_q == StRun) && bus.m_en && bus.m_rw;
      ram_we    = ld_we || wr_req;
      ram_addr  = ld_we ? cnt_q : bus.m_addr;
      ram_wdata = ld_we ? DATA_W'({hi_q, bus.ld_byte}) : bus.m_data;
      m_ready_d = rd_req || wr_req;
      m_q_d     = rd_req ? mem[bus.m_addr] : m_q_q;
      io_d      = (wr_req && (bus.m_addr == IO_ADDR)) ? bus.m_data : io_q;
   end

   // RAM has no reset so contents survive a reset of the control logic
   always_ff @(posedge clock) begin
      if (ram_we) begin
         mem[ram_addr] <= ram_wdata;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= StLoadHi;
         hi_q      <= '0;
         cnt_q     <= '0;
         m_q_q     <= '0;
         m_ready_q <= 1'b0;
         io_q      <= '0;
      end else begin
         state_q   <= state_d;
         hi_q      <= hi_d;
         cnt_q     <= cnt_d;
         m_q_q     <= m_q_d;
         m_ready_q <= m_ready_d;
         io_q      <= io_d;
      end
   end

   assign bus.m_q      = m_q_q;
   assign bus.m_ready  = m_ready_q;
   assign bus.io_out   = io_q;
   assign bus.run      = (state_q == StRun);
   assign bus.ld_ready = (state_q != StRun);

endmodule

// File: tb/tb_bus_memory.sv
// Scoreboard bench for bus_memory: loads images, issues bus requests and checks
// completions against expected data queued when each request is driven.
module tb_bus_memory;

   localparam int unsigned ADDR_W = 12;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned DEPTH  = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] IO_ADDR = 12'hFFF;

   typedef struct packed {
      logic              rd;
      logic [DATA_W-1:0] data;
   } sb_t;

   logic clock = 1'b0;
   logic reset = 1'b1;

   int n_checks = 0;
   int n_fail   = 0;
   int n_req    = 0;
   int n_ready  = 0;

   sb_t               sb [$];
   logic [DATA_W-1:0] exp_mem [DEPTH];
   logic [DATA_W-1:0] last_q = '0;

   bus_memory_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   bus_memory #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .IO_ADDR (IO_ADDR)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] word_val(input int w);
      return DATA_W'(w * 37 + 16'h1357);
   endfunction

   // Completion monitor: pops one scoreboard entry per m_ready pulse
   always @(posedge clock) begin
      sb_t e;
      #1;
      if (!reset && bus.m_ready) begin
         n_ready++;
         if (sb.size() == 0) begin
            check_eq("unexpected_ready", 32'(bus.m_ready), 32'd0);
         end else begin
            e = sb.pop_front();
            if (e.rd) begin
               check_eq("rd_data", 32'(bus.m_q), 32'(e.data));
               last_q = e.data;
            end else begin
               check_eq("wr_q_hold", 32'(bus.m_q), 32'(last_q));
            end
         end
      end
   end

   task automatic bus_req(input logic rw, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] data);
      sb_t e;
      @(negedge clock);
      bus.m_en   = 1'b1;
      bus.m_rw   = rw;
      bus.m_addr = addr;
      bus.m_data = data;
      e.rd   = !rw;
      e.data = rw ? '0 : exp_mem[addr];
      if (rw) exp_mem[addr] = data;
      sb.push_back(e);
      n_req++;
   endtask

   task automatic bus_idle();
      @(negedge clock);
      bus.m_en = 1'b0;
      bus.m_rw = 1'b0;
   endtask

   task automatic ld_send(input logic [7:0] b, input logic last);
      @(negedge clock);
      bus.ld_valid = 1'b1;
      bus.ld_byte  = b;
      bus.ld_last  = last;
   endtask

   task automatic ld_stop();
      @(negedge clock);
      bus.ld_valid = 1'b0;
      bus.ld_last  = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      last_q = '0;
      sb.delete();
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      bus.m_en     = 1'b0;
      bus.m_rw     = 1'b0;
      bus.m_addr   = '0;
      bus.m_data   = '0;
      bus.ld_valid = 1'b0;
      bus.ld_byte  = '0;
      bus.ld_last  = 1'b0;

      #3;
      check_eq("rst_m_q", 32'(bus.m_q), 32'd0);
      check_eq("rst_m_ready", 32'(bus.m_ready), 32'd0);
      check_eq("rst_ld_ready", 32'(bus.ld_ready), 32'd1);
      check_eq("rst_run", 32'(bus.run), 32'd0);
      check_eq("rst_io_out", 32'(bus.io_out), 32'd0);
      @(negedge clock);
      reset = 1'b0;

      // Basic four-byte image
      ld_send(8'h12, 1'b0);
      ld_send(8'h34, 1'b0);
      ld_send(8'hAB, 1'b0);
      @(posedge clock); #1;
      check_eq("run_before_last", 32'(bus.run), 32'd0);
      ld_send(8'hCD, 1'b1);
      @(posedge clock); #1;
      check_eq("run_after_cd", 32'(bus.run), 32'd1);
      check_eq("ld_ready_run", 32'(bus.ld_ready), 32'd0);
      ld_stop();
      exp_mem[0] = 16'h1234;
      exp_mem[1] = 16'hABCD;

      bus_req(1'b0, 12'd0, '0);
      bus_req(1'b0, 12'd1, '0);
      bus_idle();
      repeat (2) @(negedge clock);

      // Bytes in RUN are ignored
      ld_send(8'hEE, 1'b1);
      ld_send(8'hEE, 1'b1);
      ld_stop();
      bus_req(1'b0, 12'd0, '0);
      bus_idle();

      // Write to IO_ADDR then read it back-to-back
      bus_req(1'b1, IO_ADDR, 16'h5A5A);
      bus_req(1'b0, IO_ADDR, '0);
      check_eq("wr_ready", 32'(bus.m_ready), 32'd1);
      check_eq("io_out_wr", 32'(bus.io_out), 32'h5A5A);
      bus_idle();
      check_eq("rd_ready_b2b", 32'(bus.m_ready), 32'd1);
      @(negedge clock);
      check_eq("ready_drops", 32'(bus.m_ready), 32'd0);

      // Reset in the middle of a read completion
      bus_req(1'b0, 12'd1, '0);
      @(posedge clock); #2;
      reset  = 1'b1;
      last_q = '0;
      #1;
      check_eq("midrst_m_ready", 32'(bus.m_ready), 32'd0);
      check_eq("midrst_m_q", 32'(bus.m_q), 32'd0);
      check_eq("midrst_run", 32'(bus.run), 32'd0);
      check_eq("midrst_ld_ready", 32'(bus.ld_ready), 32'd1);
      check_eq("midrst_io_out", 32'(bus.io_out), 32'd0);
      bus_idle();
      reset = 1'b0;

      // m_en during load is ignored; ld_last on a high byte is ignored
      @(negedge clock);
      bus.m_en   = 1'b1;
      bus.m_rw   = 1'b1;
      bus.m_addr = 12'd1;
      bus.m_data = 16'h0000;
      @(posedge clock); #1;
      check_eq("load_no_ready", 32'(bus.m_ready), 32'd0);
      ld_send(8'h77, 1'b1);
      bus.m_en = 1'b0;
      @(posedge clock); #1;
      check_eq("hi_last_ignored", 32'(bus.run), 32'd0);
      ld_send(8'h88, 1'b1);
      @(posedge clock); #1;
      check_eq("lo_last_run", 32'(bus.run), 32'd1);
      ld_stop();
      exp_mem[0] = 16'h7788;
      bus_req(1'b0, 12'd0, '0);
      bus_req(1'b0, 12'd1, '0);
      bus_req(1'b0, IO_ADDR, '0);
      bus_idle();
      repeat (2) @(negedge clock);

      // Full-depth stream without ld_last, then one more word to show the wrap
      do_reset();
      for (int w = 0; w < int'(DEPTH); w++) begin
         ld_send(word_val(w) >> 8, 1'b0);
         ld_send(word_val(w) & 16'hFF, 1'b0);
         exp_mem[w] = word_val(w);
      end
      @(posedge clock); #1;
      check_eq("wrap_no_run", 32'(bus.run), 32'd0);
      ld_send(word_val(DEPTH) >> 8, 1'b0);
      ld_send(word_val(DEPTH) & 16'hFF, 1'b1);
      @(posedge clock); #1;
      check_eq("wrap_run", 32'(bus.run), 32'd1);
      ld_stop();
      exp_mem[0] = word_val(DEPTH);
      check_eq("ld_io_untouched", 32'(bus.io_out), 32'd0);
      bus_req(1'b0, 12'd0, '0);
      bus_req(1'b0, 12'd1, '0);
      bus_req(1'b0, 12'd2, '0);
      bus_req(1'b0, IO_ADDR, '0);
      bus_req(1'b1, 12'd2, 16'hBEEF);
      bus_req(1'b0, 12'd2, '0);
      bus_idle();
      repeat (3) @(negedge clock);

      check_eq("sb_drained", 32'(sb.size()), 32'd0);
      check_eq("ready_count", 32'(n_ready), 32'(n_req));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
